// File: rtl/fec_pkg.sv
// Shared types and defaults for the FEC link scheduler.
// Holds the link state encoding and counter sizing helper.
package fec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DL_ACTIVE,
        UL_ACTIVE,
        GUARD
    } fec_link_state_t;

    localparam int GUARD_CYC_DEF  = 4;
    localparam int UL_WIN_CYC_DEF = 64;
    localparam int DL_MAX_CYC_DEF = 256;

    // Guard also runs on the shared counter, so it has to fit as well.
    function automatic int timer_width(input int dl_max, input int ul_win,
                                       input int guard);
        int m;
        m = dl_max;
        if (ul_win > m) m = ul_win;
        if (guard > m) m = guard;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fec_cyc_timer.sv
// Shared in-state cycle counter with limit compare.
// Holds the 1-based cycle index within the current state; saturates.
module fec_cyc_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic         expired
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= ONE;
        end else if (cnt != '1) begin
            cnt <= cnt + ONE;
        end
    end

    assign expired = (cnt == limit);

endmodule

// File: rtl/fec_link_scheduler.sv
// Half-duplex ASK link arbiter: grants downlink or uplink ownership,
// enforces watchdog / listen limits and a guard gap between owners.
module fec_link_scheduler
    import fec_pkg::*;
#(
    parameter int GUARD_CYC  = GUARD_CYC_DEF,
    parameter int UL_WIN_CYC = UL_WIN_CYC_DEF,
    parameter int DL_MAX_CYC = DL_MAX_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic dl_req,
    input  logic dl_done,
    input  logic ul_req,
    input  logic ul_done,
    output logic dl_en,
    output logic ul_en,
    output logic busy,
    output logic dl_timeout,
    output logic ul_expired
);

    localparam int CW = timer_width(DL_MAX_CYC, UL_WIN_CYC, GUARD_CYC);

    fec_link_state_t state;
    fec_link_state_t state_nx;

    logic          rr_dl;
    logic          clear;
    logic          expired;
    logic [CW-1:0] limit;

    fec_cyc_timer #(
        .W(CW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .limit   (limit),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rr_dl <= 1'b1;
            dl_en <= 1'b0;
            ul_en <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            dl_en <= (state_nx == DL_ACTIVE);
            ul_en <= (state_nx == UL_ACTIVE);
            busy  <= (state_nx != IDLE);
            // Pointer favours the direction not granted last.
            if (state == IDLE && state_nx == DL_ACTIVE) begin
                rr_dl <= 1'b0;
            end else if (state == IDLE && state_nx == UL_ACTIVE) begin
                rr_dl <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (dl_req && (!ul_req || rr_dl)) begin
                    state_nx = DL_ACTIVE;
                end else if (ul_req) begin
                    state_nx = UL_ACTIVE;
                end
            end
            DL_ACTIVE: begin
                if (dl_done || expired) state_nx = GUARD;
            end
            UL_ACTIVE: begin
                if (ul_done || expired) state_nx = GUARD;
            end
            GUARD: begin
                if (expired) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        limit      = '1;
        clear      = (state_nx != state);
        dl_timeout = 1'b0;
        ul_expired = 1'b0;
        unique case (state)
            DL_ACTIVE: begin
                limit      = CW'(DL_MAX_CYC);
                dl_timeout = expired && !dl_done;
            end
            UL_ACTIVE: begin
                limit      = CW'(UL_WIN_CYC);
                ul_expired = expired && !ul_done;
            end
            GUARD:   limit = CW'(GUARD_CYC);
            default: limit = '1;
        endcase
    end

endmodule
